// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if: signal bundle between the core (fetch and load/store requesters),
// the memory arbiter and the shared memory bus.
//   Fetch port : insn_start, insn_addr[29:0]            -> insn_ready, insn_data[31:0]
//   Data port  : data_start, data_addr[29:0], data_write,
//                data_wr[31:0]                          -> data_ready, data_rd[31:0]
//   Bus port   : bus_start, bus_addr[29:0], bus_write,
//                bus_data_wr[31:0]                      <- bus_ready, bus_data_rd[31:0]
// Modports:
//   slave  : the arbiter's view (accepts core requests, drives the bus)
//   master : the environment's view (core requesters plus memory responder)
interface core_mem_arbiter_if;
  logic        insn_start;
  logic [29:0] insn_addr;
  logic        insn_ready;
  logic [31:0] insn_data;

  logic        data_start;
  logic [29:0] data_addr;
  logic        data_write;
  logic [31:0] data_wr;
  logic        data_ready;
  logic [31:0] data_rd;

  logic        bus_start;
  logic [29:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic        bus_ready;
  logic [31:0] bus_data_rd;

  modport slave (
    input  insn_start, insn_addr, data_start, data_addr, data_write, data_wr,
    input  bus_ready, bus_data_rd,
    output insn_ready, insn_data, data_ready, data_rd,
    output bus_start, bus_addr, bus_write, bus_data_wr
  );

  modport master (
    output insn_start, insn_addr, data_start, data_addr, data_write, data_wr,
    output bus_ready, bus_data_rd,
    input  insn_ready, insn_data, data_ready, data_rd,
    input  bus_start, bus_addr, bus_write, bus_data_wr
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory bus between an instruction-fetch requester and a
// load/store requester. Each requester owns a single request slot; one bus transaction is
// outstanding at a time. Data normally wins arbitration, but a waiting fetch is never
// passed over by two consecutive data grants.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   arb_if : core_mem_arbiter_if.slave (fetch port, data port, bus port)
// Bus outputs are registered; only the ready pulses and read data are combinational
// from the bus inputs.
module core_mem_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  core_mem_arbiter_if.slave    arb_if
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e      state_q, state_d;

  // Request slots: valid stays set while the request waits and while it is on the bus.
  logic        fetch_valid_q, fetch_valid_d;
  logic [29:0] fetch_addr_q, fetch_addr_d;
  logic        data_valid_q, data_valid_d;
  logic [29:0] data_addr_q, data_addr_d;
  logic        data_write_q, data_write_d;
  logic [31:0] data_wdata_q, data_wdata_d;

  logic        last_data_q, last_data_d;

  logic        bus_start_q, bus_start_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_data_wr_q, bus_data_wr_d;

  logic fetch_done, data_done;
  logic fetch_free, data_free;
  logic fetch_take, data_take;
  logic arbitrate, grant_fetch, grant_data;

  always_comb begin
    fetch_done = (state_q == StFetch) && arb_if.bus_ready;
    data_done  = (state_q == StData) && arb_if.bus_ready;

    // A slot whose transaction completes this cycle can take a new request right away.
    fetch_free = !fetch_valid_q || fetch_done;
    data_free  = !data_valid_q || data_done;
    fetch_take = arb_if.insn_start && fetch_free;
    data_take  = arb_if.data_start && data_free;

    fetch_valid_d = fetch_valid_q;
    fetch_addr_d  = fetch_addr_q;
    if (fetch_done) fetch_valid_d = 1'b0;
    if (fetch_take) begin
      fetch_valid_d = 1'b1;
      fetch_addr_d  = arb_if.insn_addr;
    end

    data_valid_d = data_valid_q;
    data_addr_d  = data_addr_q;
    data_write_d = data_write_q;
    data_wdata_d = data_wdata_q;
    if (data_done) data_valid_d = 1'b0;
    if (data_take) begin
      data_valid_d = 1'b1;
      data_addr_d  = arb_if.data_addr;
      data_write_d = arb_if.data_write;
      data_wdata_d = arb_if.data_wr;
    end

    // Arbitration happens with the bus free: in idle, or as the current transaction
    // completes. At those points every valid slot (post-capture) is waiting.
    arbitrate   = (state_q == StIdle) || fetch_done || data_done;
    grant_fetch = arbitrate && fetch_valid_d && (last_data_q || !data_valid_d);
    grant_data  = arbitrate && data_valid_d && !grant_fetch;

    state_d = state_q;
    if (fetch_done || data_done) state_d = StIdle;
    if (grant_fetch) state_d = StFetch;
    if (grant_data)  state_d = StData;

    last_data_d = last_data_q;
    if (grant_fetch) last_data_d = 1'b0;
    if (grant_data)  last_data_d = 1'b1;

    bus_start_d   = grant_fetch || grant_data;
    bus_addr_d    = bus_addr_q;
    bus_write_d   = bus_write_q;
    bus_data_wr_d = bus_data_wr_q;
    if (grant_fetch) begin
      bus_addr_d    = fetch_addr_d;
      bus_write_d   = 1'b0;
      bus_data_wr_d = '0;
    end else if (grant_data) begin
      bus_addr_d    = data_addr_d;
      bus_write_d   = data_write_d;
      bus_data_wr_d = data_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_valid_q <= 1'b0;
      fetch_addr_q  <= '0;
      data_valid_q  <= 1'b0;
      data_addr_q   <= '0;
      data_write_q  <= 1'b0;
      data_wdata_q  <= '0;
      last_data_q   <= 1'b0;
      bus_start_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_write_q   <= 1'b0;
      bus_data_wr_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_addr_q  <= fetch_addr_d;
      data_valid_q  <= data_valid_d;
      data_addr_q   <= data_addr_d;
      data_write_q  <= data_write_d;
      data_wdata_q  <= data_wdata_d;
      last_data_q   <= last_data_d;
      bus_start_q   <= bus_start_d;
      bus_addr_q    <= bus_addr_d;
      bus_write_q   <= bus_write_d;
      bus_data_wr_q <= bus_data_wr_d;
    end
  end

  // Ready pulses are masked during reset so an abandoned transaction never completes.
  assign arb_if.insn_ready  = fetch_done && !rst;
  assign arb_if.data_ready  = data_done && !rst;
  assign arb_if.insn_data   = arb_if.bus_data_rd;
  assign arb_if.data_rd     = arb_if.bus_data_rd;
  assign arb_if.bus_start   = bus_start_q;
  assign arb_if.bus_addr    = bus_addr_q;
  assign arb_if.bus_write   = bus_write_q;
  assign arb_if.bus_data_wr = bus_data_wr_q;

  // A requester must not restart while its slot is still occupied; such starts are dropped.
  a_insn_start_busy: assert property (@(posedge clk) disable iff (rst)
      !(arb_if.insn_start && !fetch_free))
    else $warning("insn_start dropped: fetch slot occupied");
  a_data_start_busy: assert property (@(posedge clk) disable iff (rst)
      !(arb_if.data_start && !data_free))
    else $warning("data_start dropped: data slot occupied");

endmodule
